four_bit_rcs: RTL and testbench
===============================

Name: four_bit_rcs

Overview:
- 4-bit ripple-carry adder/subtractor with registered outputs.
- Sub=0 computes A+B. Sub=1 computes A−B as A + ~B + 1.
- A single control bit XORs B and seeds the carry-in of the ripple chain.
- Used as a small datapath arithmetic element. Results are registered on clk, so downstream logic sees a clean, cycle-aligned sum, carry and overflow.

Parameters:
- WIDTH, 4, operand/result width. The block is specified and verified at 4; other values are legal but not required to be tested.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- A  input  4  operand A, unsigned or two's complement
- B  input  4  operand B
- Sub  input  1  0 = add, 1 = subtract
- S  output  4  registered sum/difference, modulo 2^4
- Cout  output  1  registered carry out of the MSB stage
- V  output  1  registered signed-overflow flag

Behaviour:
- Combinational core:
  - Bi = B[i] XOR Sub.
  - c0 = Sub.
  - Four full-adder stages in ripple order: s[i] = A[i]^Bi^c[i]; c[i+1] = majority(A[i], Bi, c[i]).
  - Cout = c4.
  - V = c4 XOR c3.
- Registering and latency:
  - S, Cout and V are registered on the rising edge of clk.
  - Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
  - A new operation is accepted every cycle. There is no handshake and no stall.
- Reset:
  - When rst=1 at a rising edge: S=0000, Cout=0, V=0, regardless of A, B and Sub.
  - Reset has priority over the datapath.
  - Deasserting rst resumes normal operation on the next edge. Outputs then reflect the inputs sampled at that edge.
  - Reset asserted mid-stream discards the in-flight result. There is no other state.
- Carry semantics:
  - Add: Cout = unsigned carry, i.e. A+B ≥ 16.
  - Subtract: Cout = NOT borrow. Cout=1 iff A ≥ B unsigned.
  - Equal operands (A−A): S=0000, Cout=1.
- Overflow: V=1 iff the two's-complement result is out of range [−8, 7].
- Wrap-around:
  - 1111+0001 gives S=0000, Cout=1, V=0.
  - 0000−0001 gives S=1111, Cout=0, V=0.
  - 1000−0001 gives S=0111, Cout=1, V=1.
- Sub toggling: if Sub changes between cycles with operands held, each registered result corresponds only to the Sub value sampled at its own edge.
- Structure and reset safety:
  - The carry chain is a structural ripple of four full-adder instances; no behavioural "+" on the full vector.
  - No X propagation after reset: all output flops have defined reset values.

Decomposition:
- Shared package: WIDTH default constant; localparam for the reset value of S (all zeros).
- Sub-module full_adder: ports a, b, cin → s, cout; purely combinational.
  - four_bit_rcs instantiates four copies (generate loop).
  - XOR-inversion, overflow logic and the output register live in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with A=1111, B=1111, Sub=1 → S=0000, Cout=0, V=0. Release rst; the next edge produces S=0000, Cout=1, V=0.
- Add, 5+3: A=0101, B=0011, Sub=0 → one cycle later S=1000, Cout=0, V=1 (signed 5+3 overflows).
- Subtract, positive results:
  - 5−3: A=0101, B=0011, Sub=1 → S=0010, Cout=1, V=0.
  - 9−4: A=1001, B=0100, Sub=1 → S=0101, Cout=1, V=1.
- Negative results:
  - 1−2: A=0001, B=0010, Sub=1 → S=1111, Cout=0, V=0.
  - −1−1: A=1111, B=0001, Sub=1 → S=1110, Cout=1, V=0.
- Back-to-back and latency: apply the five vectors above on consecutive edges with no gaps. Each output appears exactly one cycle after its inputs. Then assert rst for one cycle mid-stream → that cycle's output is zero and the following vector resumes correctly.
- Exhaustive: all 512 combinations of A, B and Sub → compare S, Cout and V against a reference model (A ± B mod 16, carry/borrow, signed range check) one cycle later.

Source files
------------

// File: rtl/four_bit_rcs_pkg.sv
// Shared constants for the ripple-carry adder/subtractor.
package four_bit_rcs_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam logic [DEFAULT_WIDTH-1:0] S_RST_VAL = '0;
endpackage

// File: rtl/four_bit_rcs_full_adder.sv
// Single-bit full adder; purely combinational, one stage of the ripple chain.
module four_bit_rcs_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/four_bit_rcs.sv
// Ripple-carry adder/subtractor with registered sum, carry-out and signed overflow.
// One-cycle latency, accepts a new operation every cycle, no stall.
module four_bit_rcs
  import four_bit_rcs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_d;
  logic             cout_q;
  logic             v_d;
  logic             v_q;

  // Subtract is A + ~B + 1: Sub both inverts B and seeds the carry chain.
  assign b_x  = B ^ {WIDTH{Sub}};
  assign c[0] = Sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    four_bit_rcs_full_adder u_fa (
      .a    (A[i]),
      .b    (b_x[i]),
      .cin  (c[i]),
      .s    (s_d[i]),
      .cout (c[i+1])
    );
  end

  assign cout_d = c[WIDTH];
  assign v_d    = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= WIDTH'(S_RST_VAL);
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      v_q    <= v_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;
endmodule

// File: tb/tb_four_bit_rcs.sv
// Scoreboard bench for four_bit_rcs: directed vectors plus exhaustive sweep.
module tb_four_bit_rcs;
  typedef struct {
    logic [3:0] s;
    logic       c;
    logic       v;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Sub;
  logic [3:0] S;
  logic       Cout;
  logic       V;

  exp_t exp_q[$];
  int   total;
  int   bad;

  four_bit_rcs dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Sub  (Sub),
    .S    (S),
    .Cout (Cout),
    .V    (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and queue the expected result.
  task automatic apply(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic sub, input logic [3:0] es, input logic ec,
                       input logic ev, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    Sub = sub;
    e.s = es;
    e.c = ec;
    e.v = ev;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Independent reference: unsigned arithmetic for S/Cout, signed range for V.
  task automatic apply_model(input logic [3:0] a, input logic [3:0] b, input logic sub,
                             input string nm);
    int ua;
    int ub;
    int sa;
    int sb;
    int res;
    logic [3:0] es;
    logic ec;
    logic ev;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    if (sub) begin
      es  = 4'((ua - ub + 16) % 16);
      ec  = (ua >= ub);
      res = sa - sb;
    end else begin
      es  = 4'((ua + ub) % 16);
      ec  = (ua + ub) >= 16;
      res = sa + sb;
    end
    ev = (res > 7) || (res < -8);
    apply(1'b0, a, b, sub, es, ec, ev, nm);
  endtask

  // Monitor: outputs are valid every cycle, so each edge retires one queued item.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (S !== e.s || Cout !== e.c || V !== e.v) begin
          bad++;
          $display("FAIL %s: got S=%b Cout=%b V=%b, expected S=%b Cout=%b V=%b",
                   e.name, S, Cout, V, e.s, e.c, e.v);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    A     = 4'b0;
    B     = 4'b0;
    Sub   = 1'b0;

    apply(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, "reset0");
    apply(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, "reset1");
    apply(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, "release_a_minus_a");

    // Back-to-back directed vectors.
    apply(1'b0, 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, "add_5p3");
    apply(1'b0, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0, "sub_5m3");
    apply(1'b0, 4'b1001, 4'b0100, 1'b1, 4'b0101, 1'b1, 1'b1, "sub_9m4");
    apply(1'b0, 4'b0001, 4'b0010, 1'b1, 4'b1111, 1'b0, 1'b0, "sub_1m2");
    apply(1'b0, 4'b1111, 4'b0001, 1'b1, 4'b1110, 1'b1, 1'b0, "sub_n1m1");

    // Reset mid-stream, then resume.
    apply(1'b1, 4'b0101, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, "mid_reset");
    apply(1'b0, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0, "resume_5m3");

    // Wrap-around corners and Sub toggling with held operands.
    apply(1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, "wrap_15p1");
    apply(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0, "wrap_0m1");
    apply(1'b0, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1, "wrap_8m1");
    apply(1'b0, 4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1, "toggle_add");
    apply(1'b0, 4'b0110, 4'b0011, 1'b1, 4'b0011, 1'b1, 1'b0, "toggle_sub");
    apply(1'b0, 4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1, "toggle_add2");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          apply_model(4'(a), 4'(b), 1'(s), $sformatf("sweep_a%0d_b%0d_s%0d", a, b, s));
        end
      end
    end

    // Let the last queued results retire, bounded.
    repeat (4) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
